bus_arbiter8: RTL and testbench

- Round-robin arbiter that shares one 16-bit bus between 8 requesters.
- Internally it sequences the existing Mux8Way16 (data select) and DMux8Way (one-hot grant decode) datapath from registered select state.
- It sits between the requesters and the shared consumer, for example a memory write port or a register-file input.
- Ownership persists across cycles and is bounded by a burst limit so no requester starves.

---
 rtl/bus_arbiter8_pkg.sv | 13 +
 rtl/DMux8Way.sv | 24 ++
 rtl/Mux8Way16.sv | 31 +++
 rtl/rr_pick8.sv | 27 ++
 rtl/bus_arbiter8.sv | 116 +++++++++++
 tb/tb_bus_arbiter8.sv | 173 +++++++++++++++++
 6 files changed

// File: rtl/bus_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin bus arbiter.
package bus_arbiter8_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int ARB_NUM_REQ   = 8;
  localparam int ARB_DATA_W    = 16;
  localparam int ARB_MAX_BURST = 4;

endpackage

// File: rtl/DMux8Way.sv
// 1-to-8 demultiplexer: in is routed to the output picked by sel.
module DMux8Way (
  input  logic       in,
  input  logic [2:0] sel,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h
);

  logic [7:0] dec;

  // one-hot decode of sel, qualified by in
  always_comb begin
    dec = 8'h00;
    if (in) dec = 8'h01 << sel;
    {h, g, f, e, d, c, b, a} = dec;
  end

endmodule

// File: rtl/Mux8Way16.sv
// 8-way, 16-bit data select.
module Mux8Way16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [15:0] e,
  input  logic [15:0] f,
  input  logic [15:0] g,
  input  logic [15:0] h,
  input  logic [2:0]  sel,
  output logic [15:0] out
);

  // plain select on sel
  always_comb begin
    out = a;
    case (sel)
      3'd0: out = a;
      3'd1: out = b;
      3'd2: out = c;
      3'd3: out = d;
      3'd4: out = e;
      3'd5: out = f;
      3'd6: out = g;
      3'd7: out = h;
      default: out = a;
    endcase
  end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin winner search: rotate req so start sits at bit 0,
// take the lowest set bit, then add start back (mod 8).
module rr_pick8 (
  input  logic [7:0] req,
  input  logic [2:0] start,
  output logic       found,
  output logic [2:0] idx
);

  logic [7:0] rot;
  logic [2:0] off;

  // rotate-right by start, priority-encode from bit 0, un-rotate
  always_comb begin
    rot   = 8'({req, req} >> start);
    found = 1'b0;
    off   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = 3'(i);
      end
    end
    idx = start + off;
  end

endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin owner of a shared 16-bit bus across 8 requesters with a
// burst limit. Owner index is registered; data select and grant decode
// are combinational off that register.
module bus_arbiter8
  import bus_arbiter8_pkg::*;
#(
  parameter int MAX_BURST = ARB_MAX_BURST, // 1..7
  parameter int CNT_W     = 3              // 2**CNT_W > MAX_BURST
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [7:0]   req,
  input  logic [127:0] data,
  output logic [7:0]   gnt,
  output logic [2:0]   sel,
  output logic         busy,
  output logic [15:0]  out
);

  arb_state_t       state, state_n;
  logic [2:0]       sel_n, ptr, ptr_n, start;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             found;
  logic [2:0]       idx;
  logic [ARB_NUM_REQ-1:0][ARB_DATA_W-1:0] lanes;
  logic [15:0]      mux_out;

  assign lanes = data;
  assign busy  = (state == ARB_OWN);

  // On a release the search starts just past the owner so the owner is
  // considered last; from idle it starts at the round-robin pointer.
  assign start = (state == ARB_OWN) ? sel + 3'd1 : ptr;

  rr_pick8 u_pick (
    .req   (req),
    .start (start),
    .found (found),
    .idx   (idx)
  );

  // state register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      sel   <= 3'd0;
      ptr   <= 3'd0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sel   <= sel_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
    end
  end

  // next-state: grant from idle, hold within burst, or hand off
  always_comb begin
    state_n = state;
    sel_n   = sel;
    ptr_n   = ptr;
    cnt_n   = cnt;
    case (state)
      ARB_IDLE: begin
        if (found) begin
          sel_n   = idx;
          cnt_n   = CNT_W'(1);
          state_n = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (req[sel] && (cnt < CNT_W'(MAX_BURST))) begin
          cnt_n = cnt + CNT_W'(1);
        end else begin
          ptr_n = sel + 3'd1;
          if (found) begin
            sel_n = idx;
            cnt_n = CNT_W'(1);
          end else begin
            state_n = ARB_IDLE;
          end
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  Mux8Way16 u_mux (
    .a   (lanes[0]),
    .b   (lanes[1]),
    .c   (lanes[2]),
    .d   (lanes[3]),
    .e   (lanes[4]),
    .f   (lanes[5]),
    .g   (lanes[6]),
    .h   (lanes[7]),
    .sel (sel),
    .out (mux_out)
  );

  DMux8Way u_dmux (
    .in  (busy),
    .sel (sel),
    .a   (gnt[0]),
    .b   (gnt[1]),
    .c   (gnt[2]),
    .d   (gnt[3]),
    .e   (gnt[4]),
    .f   (gnt[5]),
    .g   (gnt[6]),
    .h   (gnt[7])
  );

  assign out = busy ? mux_out : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed scoreboard bench plus random stress with invariant checks.
module tb_bus_arbiter8;

  localparam int MB    = 4;
  localparam int BOUND = 7 * MB + 1;

  logic         clock = 1'b0;
  logic         reset_n;
  logic [7:0]   req;
  logic [127:0] data;
  logic [7:0]   gnt;
  logic [2:0]   sel;
  logic         busy;
  logic [15:0]  out;

  bus_arbiter8 #(.MAX_BURST(MB), .CNT_W(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .out     (out)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          tag;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        busy;
    logic [15:0] out;
    bit          chk_ptr;
    logic [2:0]  ptr;
    string       name;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   stress  = 1'b0;
  int   waitc[8];

  localparam logic [15:0] L0 = 16'hC000;
  localparam logic [15:0] L2 = 16'hBEEF;
  localparam logic [15:0] L3 = 16'hC003;
  localparam logic [15:0] L4 = 16'hC004;
  localparam logic [15:0] L5 = 16'hC005;
  localparam logic [15:0] L7 = 16'hC007;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  // drive inputs at the falling edge; outputs are expected after the next rise
  task automatic step(input logic rn, input logic [7:0] r,
                      input logic [7:0] g, input logic [2:0] s, input logic b,
                      input logic [15:0] o, input bit cp, input logic [2:0] p,
                      input string nm);
    exp_t e;
    @(negedge clock);
    reset_n = rn;
    req     = r;
    e.tag = cyc + 1; e.gnt = g; e.sel = s; e.busy = b; e.out = o;
    e.chk_ptr = cp; e.ptr = p; e.name = nm;
    q.push_back(e);
  endtask

  // monitor: scoreboard compare plus invariants
  always @(posedge clock) begin
    cyc++;
    #1;
    while (q.size() > 0 && q[0].tag == cyc) begin
      chk({q[0].name, ".gnt"},  32'(gnt),  32'(q[0].gnt));
      chk({q[0].name, ".sel"},  32'(sel),  32'(q[0].sel));
      chk({q[0].name, ".busy"}, 32'(busy), 32'(q[0].busy));
      chk({q[0].name, ".out"},  32'(out),  32'(q[0].out));
      if (q[0].chk_ptr) chk({q[0].name, ".ptr"}, 32'(dut.ptr), 32'(q[0].ptr));
      void'(q.pop_front());
    end
    if (stress) begin
      chk("onehot", 32'($countones(gnt) <= 1), 32'd1);
      chk("gnt_sel_busy", 32'(gnt[sel]), 32'(busy));
      chk("cnt_max", 32'(int'(dut.cnt) <= MB), 32'd1);
      for (int i = 0; i < 8; i++) begin
        if (!reset_n || !req[i] || gnt[i]) waitc[i] = 0;
        else waitc[i]++;
        if (waitc[i] > BOUND) begin
          chk($sformatf("wait_bound[%0d]", i), 32'(waitc[i]), 32'(BOUND));
          waitc[i] = 0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req     = 8'hFF;
    data    = '0;
    for (int i = 0; i < 8; i++) data[16*i +: 16] = 16'hC000 | 16'(i);
    data[47:32] = L2;
    for (int i = 0; i < 8; i++) waitc[i] = 0;

    // reset and idle
    step(0, 8'hFF, 8'h00, 3'd0, 0, 16'h0, 1, 3'd0, "rst1");
    step(0, 8'hFF, 8'h00, 3'd0, 0, 16'h0, 1, 3'd0, "rst2");
    step(1, 8'h00, 8'h00, 3'd0, 0, 16'h0, 0, 3'd0, "idle1");
    step(1, 8'h00, 8'h00, 3'd0, 0, 16'h0, 0, 3'd0, "idle2");
    // single requester, forced release re-grants it
    step(1, 8'h04, 8'h04, 3'd2, 1, L2, 1, 3'd0, "single1");
    step(1, 8'h04, 8'h04, 3'd2, 1, L2, 0, 3'd0, "single2");
    step(1, 8'h04, 8'h04, 3'd2, 1, L2, 0, 3'd0, "single3");
    step(1, 8'h04, 8'h04, 3'd2, 1, L2, 0, 3'd0, "single4");
    step(1, 8'h04, 8'h04, 3'd2, 1, L2, 1, 3'd3, "regrant");
    step(1, 8'h04, 8'h04, 3'd2, 1, L2, 0, 3'd0, "single6");
    step(1, 8'h00, 8'h00, 3'd2, 0, 16'h0, 1, 3'd3, "to_idle");
    // round robin between 0 and 7
    step(0, 8'h00, 8'h00, 3'd0, 0, 16'h0, 1, 3'd0, "rst3");
    for (int k = 0; k < 4; k++) step(1, 8'h81, 8'h01, 3'd0, 1, L0, 0, 3'd0, "rr_own0");
    for (int k = 0; k < 4; k++) step(1, 8'h81, 8'h80, 3'd7, 1, L7, 1, 3'd1, "rr_own7");
    step(1, 8'h81, 8'h01, 3'd0, 1, L0, 1, 3'd0, "rr_back0");
    step(1, 8'h81, 8'h01, 3'd0, 1, L0, 0, 3'd0, "rr_back0b");
    step(1, 8'h00, 8'h00, 3'd0, 0, 16'h0, 1, 3'd1, "rr_idle");
    // voluntary release from owner 3 to waiting 5
    step(1, 8'h08, 8'h08, 3'd3, 1, L3, 0, 3'd0, "vol_own3");
    step(1, 8'h28, 8'h08, 3'd3, 1, L3, 0, 3'd0, "vol_own3b");
    step(1, 8'h20, 8'h20, 3'd5, 1, L5, 1, 3'd4, "vol_to5");
    // hand to 4, then reset mid-burst
    step(1, 8'h10, 8'h10, 3'd4, 1, L4, 1, 3'd6, "to4");
    step(0, 8'h10, 8'h00, 3'd0, 0, 16'h0, 1, 3'd0, "rst_mid");
    step(1, 8'h11, 8'h01, 3'd0, 1, L0, 0, 3'd0, "after_rst");
    // zero-latency data path: change owner's lane while held
    @(negedge clock);
    data[15:0] = 16'h1234;
    #1;
    chk("comb_out", 32'(out), 32'h1234);
    step(1, 8'h11, 8'h01, 3'd0, 1, 16'h1234, 0, 3'd0, "hold0");
    step(1, 8'h10, 8'h10, 3'd4, 1, L4, 1, 3'd1, "drop0_to4");
    step(1, 8'h00, 8'h00, 3'd4, 0, 16'h0, 0, 3'd0, "end_idle");
    @(negedge clock);
    @(negedge clock);
    chk("sb_drain", 32'(q.size()), 32'd0);

    // random stress with persistent requests
    stress = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
        if (req[i]) begin
          if (gnt[i]) req[i] = ($urandom_range(3) != 0);
          else        req[i] = ($urandom_range(31) != 0);
        end else begin
          req[i] = ($urandom_range(3) == 0);
        end
      end
      data = {$urandom, $urandom, $urandom, $urandom};
      reset_n = (n % 2500 != 1249);
    end
    @(negedge clock);
    stress = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
